// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, rcon table and
// scheduler state encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    EMIT
  } state_t;

  function automatic logic [31:0] rcon(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h02;
      4'd2:    b = 8'h04;
      4'd3:    b = 8'h08;
      4'd4:    b = 8'h10;
      4'd5:    b = 8'h20;
      4'd6:    b = 8'h40;
      4'd7:    b = 8'h80;
      4'd8:    b = 8'h1b;
      4'd9:    b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h0};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step, forward (inv=0) or inverted (inv=1),
// sharing a single RotWord/SubWord path between both directions.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic         inv,
  input  logic [3:0]   rc_idx,
  output logic [127:0] next_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_sel, w_sub, w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  logic [31:0] w_p0, w_p1, w_p2, w_p3;

  assign {w_w0, w_w1, w_w2, w_w3} = key;

  // In the inverse direction the previous round's last word is w7^w6.
  assign w_sel = inv ? (w_w3 ^ w_w2) : w_w3;

  sbox u_sbox0 (.i_byte(w_sel[23:16]), .o_byte(w_sub[31:24]));
  sbox u_sbox1 (.i_byte(w_sel[15:8]),  .o_byte(w_sub[23:16]));
  sbox u_sbox2 (.i_byte(w_sel[7:0]),   .o_byte(w_sub[15:8]));
  sbox u_sbox3 (.i_byte(w_sel[31:24]), .o_byte(w_sub[7:0]));

  assign w_t = w_sub ^ rcon(rc_idx);

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_n0 ^ w_w1;
  assign w_n2 = w_n1 ^ w_w2;
  assign w_n3 = w_n2 ^ w_w3;

  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;
  assign w_p0 = w_w0 ^ w_t;

  assign next_key = inv ? {w_p0, w_p1, w_p2, w_p3} : {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational.
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits at the left end so the lookup is a plain ascending slice.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX_TABLE[{i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Decryption key scheduler: expands the cipher key forward to round 10, then
// streams round keys 10..0 over valid/ready, inverting one step per accept.
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] key_out,
  output logic [3:0]   key_round,
  output logic         busy,
  output logic         done
);

  state_t       r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt, w_step_key;
  logic [3:0]   r_cnt, w_cnt_nxt, w_rc_idx;
  logic         r_done, w_done_nxt;
  logic         w_inv, w_fire;

  assign w_inv    = (r_state == EMIT);
  // Inverting round r needs the rcon used to build it, i.e. rcon(r-1).
  assign w_rc_idx = w_inv ? (r_cnt - 4'd1) : r_cnt;
  assign w_fire   = key_valid && key_ready;

  aes_key_step u_step (
    .key      (r_key),
    .inv      (w_inv),
    .rc_idx   (w_rc_idx),
    .next_key (w_step_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_key_nxt   = cipher_key;
          w_cnt_nxt   = '0;
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        w_key_nxt = w_step_key;
        if (r_cnt == 4'(NR - 1)) begin
          w_cnt_nxt   = 4'(NR);
          w_state_nxt = EMIT;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      EMIT: begin
        if (w_fire) begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_key_nxt = w_step_key;
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign key_valid = (r_state == EMIT);
  assign key_out   = key_valid ? r_key : '0;
  assign key_round = key_valid ? r_cnt : '0;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench for the inverse key scheduler using FIPS-197 directed keys.
module tb_aes_inv_key_schedule;

  logic         clk, rst_n, start, key_ready;
  logic [127:0] cipher_key, key_out;
  logic         key_valid, busy, done;
  logic [3:0]   key_round;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  bit   rand_ready = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_inv_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cipher_key (cipher_key),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_out    (key_out),
    .key_round  (key_round),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_full();
    for (int r = 10; r >= 0; r--) exp_q.push_back('{4'(r), FIPS_RK[r], 1'b1});
  endtask

  // Only the end rounds are known by hand; middle rounds check the index only.
  task automatic push_partial(input logic [127:0] rk10, input logic [127:0] rk0);
    exp_q.push_back('{4'd10, rk10, 1'b1});
    for (int r = 9; r >= 1; r--) exp_q.push_back('{4'(r), '0, 1'b0});
    exp_q.push_back('{4'd0, rk0, 1'b1});
  endtask

  task automatic do_start(input logic [127:0] k);
    cipher_key = k;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cipher_key = ~k;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout actual=0 required=1");
    end
  endtask

  // key_ready driver: always ready, or random with occasional 5-cycle stalls.
  initial begin
    int stall = 0;
    int r;
    key_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (!rand_ready) key_ready = 1;
      else if (stall > 0) begin
        key_ready = 0;
        stall--;
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          key_ready = 0;
          stall = 4;
        end else key_ready = (r > 3);
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability and done timing.
  logic         prev_stall = 0;
  logic [127:0] prev_key;
  logic [3:0]   prev_rnd;
  bit           exp_done = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
      exp_done   = 0;
    end else begin
      if (done || exp_done) chk("done_pulse", 128'(done), 128'(exp_done));
      if (done) done_seen++;
      if (prev_stall) begin
        chk("stall_valid", 128'(key_valid), 128'd1);
        chk("stall_key", key_out, prev_key);
        chk("stall_round", 128'(key_round), 128'(prev_rnd));
      end
      exp_done = 0;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key actual_round=%0d required=none", key_round);
        end else begin
          e = exp_q.pop_front();
          chk("key_round", 128'(key_round), 128'(e.rnd));
          if (e.chk) chk("key_out", key_out, e.key);
        end
        exp_done = (key_round == 4'd0);
      end
      prev_stall = key_valid && !key_ready;
      prev_key   = key_out;
      prev_rnd   = key_round;
    end
  end

  initial begin
    int n;
    rst_n = 0;
    start = 0;
    cipher_key = '0;
    #12;
    chk("rst_valid", 128'(key_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_key", key_out, 128'd0);
    chk("rst_round", 128'(key_round), 128'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // FIPS key, continuous ready, latency check
    push_full();
    do_start(FIPS_KEY);
    chk("busy_expand", 128'(busy), 128'd1);
    n = 0;
    while (!key_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 128'(n), 128'd10);
    wait_done(100);

    // FIPS key under random backpressure
    @(posedge clk); #1;
    rand_ready = 1;
    push_full();
    do_start(FIPS_KEY);
    wait_done(600);
    rand_ready = 0;

    // start pulses while busy must be ignored
    @(posedge clk); #1;
    push_full();
    do_start(FIPS_KEY);
    repeat (3) begin @(posedge clk); #1; end
    cipher_key = SEQ_KEY;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (!key_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    cipher_key = SEQ_KEY;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(100);

    // asynchronous reset in EMIT at round 6
    @(posedge clk); #1;
    push_full();
    do_start(FIPS_KEY);
    n = 0;
    while (!(key_valid && key_round == 4'd6) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_round6", 128'(key_round), 128'd6);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_valid", 128'(key_valid), 128'd0);
    chk("midrst_key", key_out, 128'd0);
    chk("midrst_round", 128'(key_round), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // zero key, then back-to-back start on the done cycle
    push_partial(ZERO_RK10, 128'd0);
    do_start(128'd0);
    wait_done(100);
    push_partial(SEQ_RK10, SEQ_KEY);
    do_start(SEQ_KEY);
    wait_done(100);

    repeat (3) begin @(posedge clk); #1; end
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    chk("done_count", 128'(done_seen), 128'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
